// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_pkg
//  Description : Shared definitions for the seven-segment scan receive path:
//                character code type, the 32-entry segment character table
//                (same contents as the character ROM init image, generated
//                from one source), anode constants and an anode classifier.
//  Revision    : 1.0  initial release
// ============================================================================
package sseg_pkg;

    typedef logic [4:0] char_code_t;

    localparam int         NUM_DIGITS  = 4;
    localparam int         NUM_CHARS   = 32;
    localparam logic [3:0] ANODE_BLANK = 4'b1111;
    localparam logic [7:0] SSEG_OFF    = 8'hFF;

    // Active-low segments, bit order {dp, g, f, e, d, c, b, a}.
    localparam logic [7:0] CHAR_TABLE [NUM_CHARS] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,  // 0-7
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,  // 8-F
        8'hBF, 8'hF7, 8'h89, 8'hC7, 8'h8C, 8'hC1, 8'hAB, 8'hA3,  // - _ H L P U n o
        8'hAF, 8'h87, 8'h91, 8'hE1, 8'hC2, 8'h8B, 8'hFF, 8'hB7   // r t y J G h ' ' =
    };

    typedef enum logic [1:0] {
        ANODE_KIND_BLANK   = 2'd0,
        ANODE_KIND_DIGIT   = 2'd1,
        ANODE_KIND_INVALID = 2'd2
    } anode_kind_t;

    typedef struct packed {
        anode_kind_t kind;
        logic [1:0]  idx;
    } anode_dec_t;

    typedef struct packed {
        logic       hit;
        char_code_t code;
    } lookup_t;

    // One-cold anode selects a digit; all-high is blank; anything else is bad.
    function automatic anode_dec_t decode_anode(input logic [3:0] anode);
        anode_dec_t r;
        r.kind = ANODE_KIND_INVALID;
        r.idx  = 2'd0;
        case (anode)
            ANODE_BLANK: r.kind = ANODE_KIND_BLANK;
            4'b1110:     begin r.kind = ANODE_KIND_DIGIT; r.idx = 2'd0; end
            4'b1101:     begin r.kind = ANODE_KIND_DIGIT; r.idx = 2'd1; end
            4'b1011:     begin r.kind = ANODE_KIND_DIGIT; r.idx = 2'd2; end
            4'b0111:     begin r.kind = ANODE_KIND_DIGIT; r.idx = 2'd3; end
            default:     r.kind = ANODE_KIND_INVALID;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_scan_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_scan_decoder_if
//  Description : Bundle between a scan source and the scan decoder.
//                anode_in/sseg_in : multiplexed display lines (source -> dec)
//                code_out         : last complete 4-character frame
//                valid_out        : one-cycle pulse on frame update
//                err_anode/err_unknown/err_timeout : one-cycle error pulses
//                master = scan source / observer, slave = decoder.
//  Revision    : 1.0  initial release
// ============================================================================
interface sseg_scan_decoder_if;
    logic [3:0]  anode_in;
    logic [7:0]  sseg_in;
    logic [19:0] code_out;
    logic        valid_out;
    logic        err_anode;
    logic        err_unknown;
    logic        err_timeout;

    modport master (
        output anode_in, sseg_in,
        input  code_out, valid_out, err_anode, err_unknown, err_timeout
    );

    modport slave (
        input  anode_in, sseg_in,
        output code_out, valid_out, err_anode, err_unknown, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/sseg_char_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_char_lookup
//  Description : Combinational reverse lookup of an 8-bit segment pattern in
//                CHAR_TABLE. Exact compare against all entries; when several
//                entries match, the lowest index wins.
//                i_sseg   : segment pattern
//                o_result : {hit, code}
//  Revision    : 1.0  initial release
// ============================================================================
module sseg_char_lookup
    import sseg_pkg::*;
(
    input  logic [7:0] i_sseg,
    output lookup_t    o_result
);

    // Scanning from the top down lets lower indices overwrite higher ones.
    always_comb begin
        o_result = '0;
        for (int i = NUM_CHARS - 1; i >= 0; i--) begin
            if (CHAR_TABLE[i] == i_sseg) begin
                o_result.hit  = 1'b1;
                o_result.code = char_code_t'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sseg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_scan_decoder
//  Description : Samples multiplexed anode/segment lines, waits for each
//                digit to settle, reverse-maps segments to character codes
//                and emits complete 4-digit frames with a valid pulse.
//                clk, rst : clock, synchronous active-high reset
//                bus      : sseg_scan_decoder_if.slave (lines in, frame and
//                           error pulses out)
//  Revision    : 1.0  initial release
// ============================================================================
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                clk,
    input  logic                rst,
    sseg_scan_decoder_if.slave  bus
);

    localparam int c_STAB_W = $clog2(SETTLE_CYCLES);
    localparam int c_IDLE_W = $clog2(TIMEOUT_CYCLES);

    // The accepting sample is the SETTLE_CYCLES-th identical one, i.e. the
    // one seen while the match count still reads SETTLE_CYCLES-2.
    localparam logic [c_STAB_W-1:0] c_STAB_ACCEPT = c_STAB_W'(SETTLE_CYCLES - 2);
    localparam logic [c_STAB_W-1:0] c_STAB_MAX    = c_STAB_W'(SETTLE_CYCLES - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST   = c_IDLE_W'(TIMEOUT_CYCLES - 1);

    localparam logic [0:0] S_WAIT = 1'b0;
    localparam logic [0:0] S_HELD = 1'b1;

    logic [3:0]                 anode_meta_q, anode_meta_d;
    logic [3:0]                 anode_sync_q, anode_sync_d;
    logic [7:0]                 sseg_meta_q,  sseg_meta_d;
    logic [7:0]                 sseg_sync_q,  sseg_sync_d;
    logic [11:0]                prev_q,       prev_d;
    logic [0:0]                 state_q,      state_d;
    logic [c_STAB_W-1:0]        stab_q,       stab_d;
    logic [c_IDLE_W-1:0]        idle_q,       idle_d;
    logic [NUM_DIGITS-1:0][4:0] digit_q,      digit_d;
    logic [NUM_DIGITS-1:0]      seen_q,       seen_d;
    logic [19:0]                code_q,       code_d;
    logic                       valid_q,      valid_d;
    logic                       err_anode_q,  err_anode_d;
    logic                       err_unknown_q, err_unknown_d;
    logic                       err_timeout_q, err_timeout_d;

    logic [11:0] w_sample;
    logic        w_same;
    anode_dec_t  w_dec;
    lookup_t     w_lookup;
    logic        w_accept;
    logic        w_write;
    logic        w_frame;

    assign w_sample = {anode_sync_q, sseg_sync_q};
    assign w_same   = (w_sample == prev_q);
    assign w_dec    = decode_anode(anode_sync_q);

    sseg_char_lookup u_lookup (
        .i_sseg   (sseg_sync_q),
        .o_result (w_lookup)
    );

    always_comb begin
        anode_meta_d  = bus.anode_in;
        anode_sync_d  = anode_meta_q;
        sseg_meta_d   = bus.sseg_in;
        sseg_sync_d   = sseg_meta_q;
        prev_d        = w_sample;
        state_d       = state_q;
        stab_d        = stab_q;
        idle_d        = idle_q;
        digit_d       = digit_q;
        seen_d        = seen_q;
        code_d        = code_q;
        valid_d       = 1'b0;
        err_anode_d   = 1'b0;
        err_unknown_d = 1'b0;
        err_timeout_d = 1'b0;
        w_accept      = 1'b0;
        w_write       = 1'b0;
        w_frame       = 1'b0;

        // Settle detection: one accept per stable run of {anode, sseg}.
        case (state_q)
            S_WAIT: begin
                if (!w_same || w_dec.kind == ANODE_KIND_BLANK) begin
                    stab_d = '0;
                end else if (stab_q == c_STAB_ACCEPT) begin
                    w_accept = 1'b1;
                    state_d  = S_HELD;
                    stab_d   = c_STAB_MAX;
                end else if (stab_q != c_STAB_MAX) begin
                    stab_d = stab_q + 1'b1;
                end
            end
            S_HELD: begin
                if (!w_same) begin
                    state_d = S_WAIT;
                    stab_d  = '0;
                end
            end
            default: begin
                state_d = S_WAIT;
                stab_d  = '0;
            end
        endcase

        // Frame emit clears seen first so a same-cycle accept lands in the
        // next frame; code_out takes the digits as they were before it.
        if (seen_q == '1) begin
            w_frame = 1'b1;
            code_d  = digit_q;
            valid_d = 1'b1;
            seen_d  = '0;
        end

        if (w_accept) begin
            if (w_dec.kind == ANODE_KIND_DIGIT) begin
                if (w_lookup.hit) begin
                    digit_d[w_dec.idx] = w_lookup.code;
                    seen_d[w_dec.idx]  = 1'b1;
                    w_write            = 1'b1;
                end else begin
                    err_unknown_d = 1'b1;
                end
            end else begin
                err_anode_d = 1'b1;
            end
        end

        // Idle counter runs from the last successful accept; it only fires
        // when there is a partial frame to throw away, otherwise it parks.
        if (w_write) begin
            idle_d = '0;
        end else if (idle_q == c_IDLE_LAST) begin
            if (seen_q != '0 && !w_frame) begin
                seen_d        = '0;
                err_timeout_d = 1'b1;
                idle_d        = '0;
            end
        end else begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            anode_meta_q  <= ANODE_BLANK;
            anode_sync_q  <= ANODE_BLANK;
            sseg_meta_q   <= SSEG_OFF;
            sseg_sync_q   <= SSEG_OFF;
            prev_q        <= {ANODE_BLANK, SSEG_OFF};
            state_q       <= S_WAIT;
            stab_q        <= '0;
            idle_q        <= '0;
            digit_q       <= '0;
            seen_q        <= '0;
            code_q        <= '0;
            valid_q       <= 1'b0;
            err_anode_q   <= 1'b0;
            err_unknown_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            anode_meta_q  <= anode_meta_d;
            anode_sync_q  <= anode_sync_d;
            sseg_meta_q   <= sseg_meta_d;
            sseg_sync_q   <= sseg_sync_d;
            prev_q        <= prev_d;
            state_q       <= state_d;
            stab_q        <= stab_d;
            idle_q        <= idle_d;
            digit_q       <= digit_d;
            seen_q        <= seen_d;
            code_q        <= code_d;
            valid_q       <= valid_d;
            err_anode_q   <= err_anode_d;
            err_unknown_q <= err_unknown_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.code_out    = code_q;
    assign bus.valid_out   = valid_q;
    assign bus.err_anode   = err_anode_q;
    assign bus.err_unknown = err_unknown_q;
    assign bus.err_timeout = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sseg_scan_decoder
//  Description : Scoreboard bench for sseg_scan_decoder. A reference model
//                watches the driven lines, predicts frames and error pulses
//                with their arrival cycle, and a monitor matches them
//                against the decoder outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sseg_scan_decoder;
    import sseg_pkg::*;

    localparam int SETTLE = 4;
    localparam int TMO    = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sseg_scan_decoder_if bus ();

    sseg_scan_decoder #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // kind: 0 valid_out, 1 err_anode, 2 err_unknown, 3 err_timeout
    typedef struct {
        int          kind;
        int          t;
        logic [19:0] code;
    } ev_t;
    ev_t   evq[$];
    string kname [4] = '{"valid_out", "err_anode", "err_unknown", "err_timeout"};

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic int tbl_find(input logic [7:0] s);
        for (int i = 0; i < NUM_CHARS; i++)
            if (CHAR_TABLE[i] == s) return i;
        return -1;
    endfunction

    function automatic int anode_digit(input logic [3:0] a);
        for (int k = 0; k < 4; k++)
            if (a == ~(4'b0001 << k)) return k;
        return -1;
    endfunction

    function automatic void push_ev(input int kind, input int t, input logic [19:0] code);
        ev_t e;
        e.kind = kind;
        e.t    = t;
        e.code = code;
        evq.push_back(e);
    endfunction

    // ---------------- reference model ----------------
    // A value on the lines held for SETTLE consecutive cycles is taken once.
    // Decoder outputs follow the taking cycle by 2 (errors), 3 (frame).
    logic [3:0] m_run_a;
    logic [7:0] m_run_s;
    int         m_run_len;
    logic [3:0] m_seen;
    int         m_dig [4];
    int         m_last_ref;

    initial begin
        m_run_a    = 4'hF;
        m_run_s    = 8'hFF;
        m_run_len  = 0;
        m_seen     = 4'h0;
        m_last_ref = 0;
        foreach (m_dig[k]) m_dig[k] = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_run_a   = 4'hF;
                m_run_s   = 8'hFF;
                m_run_len = 0;
                m_seen    = 4'h0;
                foreach (m_dig[k]) m_dig[k] = 0;
            end else begin
                if (bus.anode_in == m_run_a && bus.sseg_in == m_run_s) begin
                    m_run_len++;
                end else begin
                    m_run_a   = bus.anode_in;
                    m_run_s   = bus.sseg_in;
                    m_run_len = 1;
                end
                if (m_run_len == SETTLE && m_run_a != 4'hF) begin
                    int d;
                    int c;
                    d = anode_digit(m_run_a);
                    c = tbl_find(m_run_s);
                    if (d < 0) begin
                        push_ev(1, cyc + 2, 20'h0);
                    end else if (c < 0) begin
                        push_ev(2, cyc + 2, 20'h0);
                    end else begin
                        m_dig[d]   = c;
                        m_seen[d]  = 1'b1;
                        m_last_ref = cyc;
                        if (m_seen == 4'hF) begin
                            push_ev(0, cyc + 3, {5'(m_dig[3]), 5'(m_dig[2]),
                                                 5'(m_dig[1]), 5'(m_dig[0])});
                            m_seen = 4'h0;
                        end
                    end
                end
                if (m_seen != 4'h0 && cyc - m_last_ref == TMO) begin
                    push_ev(3, cyc + 2, 20'h0);
                    m_seen     = 4'h0;
                    m_last_ref = cyc;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [3:0] got;
        logic [3:0] used;
        ev_t        ev;
        forever begin
            @(negedge clk);
            got  = {bus.err_timeout, bus.err_unknown, bus.err_anode, bus.valid_out};
            used = 4'h0;
            while (evq.size() > 0 && evq[0].t <= cyc) begin
                ev = evq.pop_front();
                if (ev.t < cyc) begin
                    check(kname[ev.kind], 1'b0,
                          $sformatf("no pulse seen, required at cycle %0d (now %0d)", ev.t, cyc));
                end else begin
                    check(kname[ev.kind], got[ev.kind] === 1'b1 && !used[ev.kind],
                          $sformatf("pulse=%b at cycle %0d, required 1", got[ev.kind], cyc));
                    used[ev.kind] = 1'b1;
                    if (ev.kind == 0)
                        check("code_out", bus.code_out === ev.code,
                              $sformatf("got %h required %h", bus.code_out, ev.code));
                end
            end
            for (int k = 0; k < 4; k++)
                if (got[k] !== 1'b0 && !used[k])
                    check(kname[k], 1'b0,
                          $sformatf("unexpected pulse=%b at cycle %0d, required 0", got[k], cyc));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
        bus.anode_in = a;
        bus.sseg_in  = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        drive(4'hF, 8'hFF, n);
    endtask

    initial begin
        logic [4:0] c [4];
        logic [3:0] a;
        logic [7:0] s;
        bus.anode_in = 4'hF;
        bus.sseg_in  = 8'hFF;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_code", bus.code_out === 20'h0, $sformatf("got %h required 0", bus.code_out));
        check("reset_pulses", {bus.valid_out, bus.err_anode, bus.err_unknown, bus.err_timeout} === 4'h0,
              $sformatf("got %b required 0000",
                        {bus.valid_out, bus.err_anode, bus.err_unknown, bus.err_timeout}));
        rst = 1'b0;
        blank(4);

        // basic frame {22,16,27,29}
        drive(4'b1110, CHAR_TABLE[29], 8);
        drive(4'b1101, CHAR_TABLE[27], 8);
        drive(4'b1011, CHAR_TABLE[16], 8);
        drive(4'b0111, CHAR_TABLE[22], 8);
        blank(10);

        // long hold, glitch, re-accept, then finish the frame
        drive(4'b1110, CHAR_TABLE[5], 100);
        drive(4'b1110, CHAR_TABLE[6], 2);
        drive(4'b1110, CHAR_TABLE[5], 8);
        drive(4'b1101, CHAR_TABLE[1], 8);
        drive(4'b1011, CHAR_TABLE[2], 8);
        drive(4'b0111, CHAR_TABLE[3], 8);
        blank(10);

        // invalid anode, unknown pattern
        drive(4'b1100, CHAR_TABLE[7], 8);
        blank(4);
        drive(4'b1110, 8'h5A, 8);
        blank(10);

        // partial frame times out, then a clean frame
        drive(4'b1110, CHAR_TABLE[9], 8);
        drive(4'b1101, CHAR_TABLE[10], 8);
        drive(4'b1011, CHAR_TABLE[11], 8);
        blank(90);
        drive(4'b1110, CHAR_TABLE[12], 8);
        drive(4'b1101, CHAR_TABLE[13], 8);
        drive(4'b1011, CHAR_TABLE[14], 8);
        drive(4'b0111, CHAR_TABLE[15], 8);
        blank(10);

        // blanks between digits
        drive(4'b1110, CHAR_TABLE[17], 6); blank(3);
        drive(4'b1101, CHAR_TABLE[18], 6); blank(3);
        drive(4'b1011, CHAR_TABLE[19], 6); blank(3);
        drive(4'b0111, CHAR_TABLE[20], 6); blank(10);

        // reset mid-frame
        drive(4'b1110, CHAR_TABLE[21], 8);
        drive(4'b1101, CHAR_TABLE[23], 8);
        blank(8);
        rst = 1'b1;
        @(negedge clk);
        check("rst_code", bus.code_out === 20'h0, $sformatf("got %h required 0", bus.code_out));
        check("rst_pulses", {bus.valid_out, bus.err_anode, bus.err_unknown, bus.err_timeout} === 4'h0,
              $sformatf("got %b required 0000",
                        {bus.valid_out, bus.err_anode, bus.err_unknown, bus.err_timeout}));
        rst = 1'b0;
        blank(4);
        drive(4'b1011, CHAR_TABLE[24], 8);
        drive(4'b0111, CHAR_TABLE[25], 8);
        drive(4'b1110, CHAR_TABLE[26], 8);
        drive(4'b1101, CHAR_TABLE[28], 8);
        blank(10);

        // continuous scan, four frames of random characters
        for (int f = 0; f < 4; f++) begin
            for (int d = 0; d < 4; d++) c[d] = 5'($urandom_range(0, 31));
            for (int d = 0; d < 4; d++) drive(~(4'b0001 << d), CHAR_TABLE[c[d]], 6);
        end
        blank(10);

        // random line activity
        for (int n = 0; n < 250; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70)      a = ~(4'b0001 << $urandom_range(0, 3));
            else if (r < 85) a = 4'hF;
            else             a = 4'($urandom);
            if ($urandom_range(0, 4) != 0) s = CHAR_TABLE[$urandom_range(0, 31)];
            else                           s = 8'($urandom);
            if ($urandom_range(0, 39) == 0) blank(75);
            else                            drive(a, s, $urandom_range(1, 8));
        end

        blank(100);
        check("drain", evq.size() == 0,
              $sformatf("pending events %0d, required 0", evq.size()));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sseg_scan_decoder.md
# sseg_scan_decoder

Receive-side counterpart of the display scan path. Samples the time-multiplexed anode/segment lines driven by the scan unit, de-multiplexes them into four digit slots, and reverse-maps each 8-bit segment pattern back to its 5-bit character code. It emits a complete 4-character frame with a one-cycle valid pulse. Used as a loopback checker on the board and as the scoreboard front end in display benches.

## Interface
- SETTLE_CYCLES, 4: consecutive identical synchronized samples required before a digit is accepted (min 2).
- TIMEOUT_CYCLES, 1048576: cycles without an accepted digit before a partial frame is discarded.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- anode_in  in  4  active-low digit enables; anode_in[3] is the leftmost digit.
- sseg_in  in  8  segment pattern, same encoding and bit order as the character ROM contents.
- code_out  out  20  {digit3, digit2, digit1, digit0}, 5 bits each; holds the last complete frame.
- valid_out  out  1  one-cycle pulse when code_out updates.
- err_anode  out  1  one-cycle pulse on an invalid anode pattern that met settle.
- err_unknown  out  1  one-cycle pulse on a settled segment pattern with no table match.
- err_timeout  out  1  one-cycle pulse when a partial frame is discarded.

## Operation
- Input stage: 2-flop synchronizer on {anode_in, sseg_in}. Reset value is anode 4'b1111, sseg 8'hFF.
- Anode classification of the synchronized value:
  - 4'b1110, 1101, 1011, 0111 select digit 0, 1, 2, 3 respectively.
  - 4'b1111 is blank: ignored, and it resets the stability counter.
  - Any other value is invalid.
- Sample FSM:
  - S_WAIT: compare {anode, sseg} with the previous sample. If equal, stab_cnt increments; otherwise stab_cnt is 0.
  - When stab_cnt reaches SETTLE_CYCLES-1, the sample is accepted once and the FSM moves to S_HELD.
  - S_HELD: no further accepts. Any change of {anode, sseg} returns to S_WAIT with stab_cnt 0.
- Accept action:
  - Valid anode: reverse lookup on sseg.
    - Match: write the 5-bit code into digit_reg[d] and set seen[d]. A rewrite of an already-seen digit overwrites it.
    - No match: pulse err_unknown; no write.
  - Invalid anode: pulse err_anode; no write.
- Reverse lookup: exact 8-bit compare against all 32 table entries. If entries are duplicated, the lowest index wins.
- Frame: the cycle after seen becomes 4'b1111:
  - code_out <= digit regs, valid_out = 1, seen <= 0.
  - If an accept occurs in that same cycle, its seen bit is set after the clear, so it counts toward the next frame.
- Timeout: idle_cnt counts cycles since the last successful accept and clears on each accept.
  - At TIMEOUT_CYCLES-1 with seen != 0: clear seen, pulse err_timeout, restart the count.
  - With seen == 0 the count saturates silently.
- Reset mid-frame: seen, digit regs, counters and FSM clear in the same cycle. No valid_out is produced for the partial frame.

## Timing
- Reset values: code_out 0, valid_out 0, all err_* 0, seen 0, FSM S_WAIT, stab_cnt 0, idle_cnt 0.
- Input change to accept: 2 (synchronizer) + SETTLE_CYCLES - 1 cycles after the first stable synchronized sample.
- Last accept to valid_out: 1 cycle. code_out changes in the same cycle valid_out is high.
- Pulses never last more than one cycle. err_* and valid_out may assert in the same cycle.
- stab_cnt width is clog2(SETTLE_CYCLES) and it saturates. idle_cnt width is clog2(TIMEOUT_CYCLES).

## Structure
- Shared package sseg_pkg:
  - char_code_t (5-bit).
  - CHAR_TABLE: 32 × 8-bit, identical to the character ROM init contents.
  - ANODE_BLANK = 4'b1111.
  - NUM_DIGITS = 4.
- The character ROM init file and CHAR_TABLE are generated from one source.
- Sub-module sseg_char_lookup: combinational, sseg[7:0] -> {hit, char_code_t}, priority to the lowest index.
- Top-level holds the synchronizer, the sample FSM, digit registers, seen mask, timeout counter and output registers.

## Test plan
- Drive anode 1110/1101/1011/0111 with CHAR_TABLE[29]/[27]/[16]/[22], each for 8 cycles, SETTLE_CYCLES=4 -> one valid_out with code_out = {22,16,27,29}, no errors.
- Hold one digit for 100 cycles -> exactly one accept. Toggle sseg for 2 cycles and back -> no accept from the glitch; a re-accept after settling.
- anode 1100 held 8 cycles -> single err_anode pulse, seen unchanged. sseg 8'h5A (absent from the table) on digit 0 -> single err_unknown, seen[0] stays 0.
- Three digits accepted, then blank, TIMEOUT_CYCLES=64 -> err_timeout exactly 64 cycles after the last accept. A following full frame produces a valid frame without stale digits.
- Interleave blank 4'b1111 between digits -> frame still assembles. Assert rst after 2 digits -> all outputs 0 next cycle, and no valid_out until 4 new accepts.
- Continuous scan loop with the display path at 4 frames -> 4 valid_out pulses, each code_out equal to the driven addresses.
